sdram_arbiter: RTL
==================

# sdram_arbiter

- Shares the single SDRAM controller among `NUM_PORTS` requesters (CPU, GPU/VRAM fetch, DMA).
- Arbitrates, holds the winner's command stable on the controller inputs, and handles the controller's start/busy/q_ready protocol, including refresh stalls.
- Returns read data and a one-cycle completion pulse to the granted port.
- Sits between the bus masters and the SDRAM controller, in the controller's clock domain.

## Interface

Parameters:

- `NUM_PORTS`, 3: number of requesters (2..8).
- `ADDR_W`, 24: word address width.
- `DATA_W`, 32: data width.

Ports:

- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in `NUM_PORTS`: per-port request level; held until the port's `ack`.
- `req_we` in `NUM_PORTS`: per-port write enable.
- `req_addr` in `NUM_PORTS*ADDR_W`: flattened addresses; port i is at `[i*ADDR_W +: ADDR_W]`.
- `req_d` in `NUM_PORTS*DATA_W`: flattened write data.
- `ack` out `NUM_PORTS`: one-cycle completion pulse, one-hot.
- `q` out `DATA_W`: read data of the last completed read; valid with `ack`.
- `grant` out `NUM_PORTS`: one-hot owner of the controller; 0 when free.
- `ctrl_start` out 1: start request to the controller.
- `ctrl_we` out 1: write enable to the controller.
- `ctrl_addr` out `ADDR_W`: address to the controller.
- `ctrl_d` out `DATA_W`: write data to the controller.
- `ctrl_busy` in 1: controller not idle (includes refresh).
- `ctrl_q` in `DATA_W`: controller read data.
- `ctrl_q_ready` in 1: controller completion flag; a multi-cycle level, not a pulse.
- `ctrl_init_done` in 1: controller initialisation complete.

## Operation

States: `IDLE`, `ACTIVE`, `DONE`, `SETTLE`.

- **IDLE**: if `ctrl_init_done` and any `req` is high, the picker selects a winner.
  - Register `grant`, `ctrl_we`, `ctrl_addr`, `ctrl_d` from the winner.
  - Set `ctrl_start=1` and go to `ACTIVE`.
  - With no request, or `ctrl_init_done=0`, stay in `IDLE` with all outputs low.
- **ACTIVE**: `ctrl_start` and all `ctrl_*` outputs stay constant.
  - The controller samples its inputs across several of its states, so these values must not change.
  - Exit only on the rising edge of `ctrl_q_ready`, detected against a registered `q_ready_d` copy. On that edge:
    - Capture `q <= ctrl_q` on reads; `q` is unchanged on writes.
    - Drop `ctrl_start`.
    - Go to `DONE`.
  - A refresh makes `ctrl_busy` rise without `ctrl_q_ready`. The arbiter keeps `ctrl_start` high, so the controller accepts the command after its refresh. No special handling.
- **DONE**: `ack[granted]=1` for exactly one cycle, then go to `SETTLE`.
- **SETTLE**: wait until `ctrl_busy==0` and `ctrl_q_ready==0`.
  - The controller idles through its post-precharge states with `q_ready` still high.
  - Then clear `grant` and go to `IDLE`.
- Requester rules:
  - A port deasserting `req` while granted does not abort the operation; the operation completes and `ack` still fires.
  - A port that still holds `req` in the cycle after `ack` is treated as a new request.
- Arbitration is combinational over `req`, sampled only in `IDLE`. The default is fixed priority, port 0 highest.

## Timing

- Reset values: state=`IDLE`, `grant=0`, `ack=0`, `q=0`, `ctrl_start=0`, `ctrl_we=0`, `ctrl_addr=0`, `ctrl_d=0`, `q_ready_d=0`, RR pointer=`NUM_PORTS-1`.
- Reset asserted mid-operation: return to `IDLE` immediately. No `ack` is generated; the owning master is reset alongside.
- `req` sampled in `IDLE` → `ctrl_start` high the next posedge (1-cycle latency).
- Completion: `ctrl_q_ready` rising seen at posedge N → `ack` and `q` valid during cycle N+1.
- Minimum issue-to-issue gap: `DONE` (1 cycle) + `SETTLE` (≥1 cycle) + `IDLE` (1 cycle).
- The controller drives its outputs on negedge; the arbiter samples them at posedge, a half-cycle margin. No synchronisers.
- `ctrl_q_ready` already high on entry to `ACTIVE` is not an edge. `SETTLE` guarantees it is low before any new grant.

## Configuration

- `SDRAM_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at `last_grant+1` and wraps modulo `NUM_PORTS`.
  - The pointer updates on every grant.
- `SDRAM_ARB_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Structure

- Package `sdram_arb_pkg` holds:
  - the state encoding localparams (`ST_IDLE`, `ST_ACTIVE`, `ST_DONE`, `ST_SETTLE`);
  - the default widths;
  - `MAX_PORTS=8`.
- Sub-module `sdram_arb_pick` is purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `win` and `win_idx`.
  - Its fixed/RR behaviour is selected by the macro.
- The top level holds the FSM, the command registers and the edge detector.

## Test plan

- Single read, port 1, addr `0x000123`, controller model returns `0xDEADBEEF` → `ctrl_addr=0x000123` held stable until `q_ready` rises; `ack=3'b010` for one cycle; `q=0xDEADBEEF`.
- Simultaneous `req=3'b111`, writes, RR off → grant order 0,0,0… while port 0 holds `req`; once port 0 drops `req`, grant order 1 then 2. RR on → order 0,1,2,0.
- Refresh collision: model enters a 6-cycle refresh (busy, no `q_ready`) while `ctrl_start=1` → start stays high; command accepted after refresh; exactly one `ack`.
- `ctrl_init_done=0` with `req=3'b001` → `ctrl_start` stays 0; grant issued 1 cycle after `init_done` rises.
- Back-to-back requests, `q_ready` held high for 4 cycles → second `ctrl_start` only after `busy=0` and `q_ready=0`; no spurious second `ack`.
- Reset asserted in `ACTIVE` → all outputs 0 asynchronously; next request after deassertion is served normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM state encoding and default sizes.
package sdram_arb_pkg;

  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 32;
  localparam int MAX_PORTS     = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;
  localparam state_t ST_SETTLE = 2'd3;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner picker. The search starts at ptr+1 and wraps modulo N;
// the first requesting port wins. Fixed priority (port 0 highest) is obtained
// by holding ptr at N-1, which the top level does when SDRAM_ARB_RR_EN is
// undefined; with SDRAM_ARB_RR_EN defined ptr is the last granted port.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_PORTS,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx
);

  // Rotating priority scan: first requester at or after ptr+1 wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + 1 + k) % N);
      if (!found && req[cand]) begin
        win[cand] = 1'b1;
        win_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller among NUM_PORTS requesters. Holds the granted
// command stable while the controller works (including refresh stalls), waits
// for the rising edge of ctrl_q_ready, pulses ack for one cycle and then waits
// for the controller to go fully idle before the next grant.
// Optional feature macro: SDRAM_ARB_RR_EN selects round-robin arbitration
// (default build: fixed priority, port 0 highest, no pointer register).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_d,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           q,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        ctrl_start,
  output logic                        ctrl_we,
  output logic [ADDR_W-1:0]           ctrl_addr,
  output logic [DATA_W-1:0]           ctrl_d,
  input  logic                        ctrl_busy,
  input  logic [DATA_W-1:0]           ctrl_q,
  input  logic                        ctrl_q_ready,
  input  logic                        ctrl_init_done
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   q_ready_dly_q;  // registered copy of ctrl_q_ready for edge detection

  logic [NUM_PORTS-1:0]   win;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       ptr;
  logic                   issue;
  logic                   q_ready_rise;
  logic                   settle_exit;

  logic [ADDR_W-1:0]      addr_arr [NUM_PORTS];
  logic [DATA_W-1:0]      data_arr [NUM_PORTS];

  // Unpack the flattened per-port buses.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_d[gi*DATA_W +: DATA_W];
  end

  assign issue        = (state_q == ST_IDLE) && ctrl_init_done && (|req);
  assign q_ready_rise = ctrl_q_ready && !q_ready_dly_q;
  assign settle_exit  = (state_q == ST_SETTLE) && !ctrl_busy && !ctrl_q_ready;

`ifdef SDRAM_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  // Round-robin pointer: remembers the last granted port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
    end else if (issue) begin
      rr_ptr_q <= win_idx;
    end
  end

  assign ptr = rr_ptr_q;
`else
  // Constant start point makes the rotating scan a fixed-priority search.
  assign ptr = IDX_W'(NUM_PORTS - 1);
`endif

  sdram_arb_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (issue)        state_d = ST_ACTIVE;
      ST_ACTIVE: if (q_ready_rise) state_d = ST_DONE;
      ST_DONE:                     state_d = ST_SETTLE;
      ST_SETTLE: if (settle_exit)  state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Command, grant and read-data registers; the command is frozen outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      q_ready_dly_q <= 1'b0;
    end else begin
      q_ready_dly_q <= ctrl_q_ready;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            grant_q <= win;
            we_q    <= req_we[win_idx];
            addr_q  <= addr_arr[win_idx];
            wdata_q <= data_arr[win_idx];
          end else begin
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (q_ready_rise && !we_q) begin
            rdata_q <= ctrl_q;
          end
        end
        ST_SETTLE: begin
          if (settle_exit) begin
            grant_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: start while ACTIVE, one-cycle ack to the owner in DONE.
  always_comb begin
    ctrl_start = (state_q == ST_ACTIVE);
    ack        = (state_q == ST_DONE) ? grant_q : '0;
  end

  assign grant     = grant_q;
  assign ctrl_we   = we_q;
  assign ctrl_addr = addr_q;
  assign ctrl_d    = wdata_q;
  assign q         = rdata_q;

endmodule
